vec_mem_sequencer: RTL and testbench

- MEM-stage block directly downstream of the EX/MEM pipeline register and directly upstream of the MEM/WB register.
- Serialises scalar and 16-element vector loads/stores onto the single-port 16-bit data RAM, one element per beat.
- Assembles vector load data into a 256-bit word and holds the pipeline with a stall until the access completes.
- Replaces the separate address, input and output element managers with a single FSM.

---
 rtl/vmem_pkg.sv | 10 +
 rtl/vec_mem_sequencer_if.sv | 27 ++
 rtl/vmem_read_collector.sv | 41 ++++
 rtl/vec_mem_sequencer.sv | 101 ++++++++++
 tb/tb_vec_mem_sequencer.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/vmem_pkg.sv
// vmem_pkg: shared constants and types for the vector memory sequencer.
package vmem_pkg;
    localparam int VLEN   = 16;
    localparam int ELEM_W = 16;
    localparam int ADDR_W = 19;
    localparam int IDX_W  = $clog2(VLEN);
    localparam int CNT_W  = 19;
    typedef enum logic [2:0] {IDLE, WRITE, ISSUE, DRAIN, DONE} vmem_state_t;
    typedef logic [VLEN-1:0][ELEM_W-1:0] vec_t;
endpackage

// File: rtl/vec_mem_sequencer_if.sv
// vec_mem_sequencer_if: request, RAM and load-result signals of the MEM stage.
interface vec_mem_sequencer_if;
    import vmem_pkg::*;
    logic              req_valid;
    logic              req_write;
    logic              req_vector;
    logic [ADDR_W-1:0] req_addr;
    logic [ELEM_W-1:0] req_wdata_s;
    vec_t              req_wdata_v;
    logic [4:0]        req_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [ELEM_W-1:0] mem_wdata;
    logic              mem_wren;
    logic [ELEM_W-1:0] mem_rdata;
    logic              stall;
    logic              ld_valid;
    vec_t              ld_data;
    logic [4:0]        ld_rd;
    modport slave (
        input  req_valid, req_write, req_vector, req_addr, req_wdata_s, req_wdata_v, req_rd, mem_rdata,
        output mem_addr, mem_wdata, mem_wren, stall, ld_valid, ld_data, ld_rd
    );
    modport master (
        output req_valid, req_write, req_vector, req_addr, req_wdata_s, req_wdata_v, req_rd, mem_rdata,
        input  mem_addr, mem_wdata, mem_wren, stall, ld_valid, ld_data, ld_rd
    );
endinterface

// File: rtl/vmem_read_collector.sv
// vmem_read_collector: RD_LAT-deep valid/index delay line that drops returning RAM data into the load vector.
module vmem_read_collector
    import vmem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic              clr_i,
    input  logic [ELEM_W-1:0] rdata_i,
    output logic              cap_valid_o,
    output logic [IDX_W-1:0]  cap_idx_o,
    output vec_t              data_o
);
    logic [RD_LAT-1:0]            vld_q;
    logic [RD_LAT-1:0][IDX_W-1:0] idx_q;
    vec_t                         data_q;
    assign cap_valid_o = vld_q[RD_LAT-1];
    assign cap_idx_o   = idx_q[RD_LAT-1];
    assign data_o      = data_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= '0;
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q[0] <= issue_i;
            idx_q[0] <= idx_i;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                idx_q[k] <= idx_q[k-1];
            end
            if (clr_i)
                data_q <= '0;
            else if (cap_valid_o)
                data_q[cap_idx_o] <= rdata_i;
        end
    end
endmodule

// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer: serialises scalar/vector loads and stores onto a single-port RAM, stalling the pipeline.
// Define VMEM_STALL_COUNT_EN to build the saturating stall_count performance counter.
module vec_mem_sequencer
    import vmem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    vec_mem_sequencer_if.slave bus,
    output logic [CNT_W-1:0]  stall_count
);
    vmem_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [ADDR_W-1:0] base_q, base_d;
    vec_t              wdata_q, wdata_d;
    logic              write_q, write_d;
    logic [4:0]        rd_q, rd_d;
    logic              cap_valid;
    logic [IDX_W-1:0]  cap_idx;
    logic              ld_accept;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rd_q    <= rd_d;
        end
    end
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        write_d = write_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                base_d  = bus.req_addr;
                wdata_d = bus.req_vector ? bus.req_wdata_v : vec_t'({{(VLEN-1)*ELEM_W{1'b0}}, bus.req_wdata_s});
                last_d  = bus.req_vector ? IDX_W'(VLEN-1) : '0;
                write_d = bus.req_write;
                rd_d    = bus.req_write ? rd_q : bus.req_rd;
                idx_d   = '0;
                state_d = bus.req_write ? WRITE : ISSUE;
            end
            WRITE, ISSUE: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == last_q)
                    state_d = write_q ? DONE : DRAIN;
            end
            DRAIN: if (cap_valid && cap_idx == last_q) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    assign ld_accept    = state_q == IDLE && bus.req_valid && !bus.req_write;
    assign bus.mem_addr  = (state_q == WRITE || state_q == ISSUE) ? base_q + ADDR_W'(idx_q) : '0;
    assign bus.mem_wdata = state_q == WRITE ? wdata_q[idx_q] : '0;
    assign bus.mem_wren  = state_q == WRITE;
    // DONE drops stall so EX/MEM advances exactly once per access.
    assign bus.stall     = state_q == IDLE ? bus.req_valid : state_q != DONE;
    assign bus.ld_valid  = state_q == DONE && !write_q;
    assign bus.ld_rd     = rd_q;
    vmem_read_collector #(.RD_LAT(RD_LAT)) u_collector (
        .clk        (clk),
        .rst        (rst),
        .issue_i    (state_q == ISSUE),
        .idx_i      (idx_q),
        .clr_i      (ld_accept),
        .rdata_i    (bus.mem_rdata),
        .cap_valid_o(cap_valid),
        .cap_idx_o  (cap_idx),
        .data_o     (bus.ld_data)
    );
`ifdef VMEM_STALL_COUNT_EN
    logic [CNT_W-1:0] cnt_q;
    // Counts the stalled cycles spent working on an access, i.e. after acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else if (bus.stall && state_q != IDLE && !(&cnt_q))
            cnt_q <= cnt_q + 1'b1;
    end
    assign stall_count = cnt_q;
`else
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_vec_mem_sequencer.sv
// tb_vec_mem_sequencer: directed checks of stores, loads, wrap-around, mid-access reset and stall counting.
module tb_vec_mem_sequencer;
    import vmem_pkg::*;
    logic              clk;
    logic              rst;
    logic [CNT_W-1:0]  stall_count;
    logic [ELEM_W-1:0] rdata_q;
    bit   [ELEM_W-1:0] ram [0:(1<<ADDR_W)-1];
    int                checks;
    int                errors;
    vec_mem_sequencer_if bus();
    vec_mem_sequencer #(.RD_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .stall_count(stall_count)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) begin
        rdata_q <= ram[bus.mem_addr];
        if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = rdata_q;
    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input string tag);
        bus.req_valid = 1'b0;
        step();
        check({tag, "_idle_stall"}, 256'(bus.stall), 256'(0));
        check({tag, "_idle_wren"}, 256'(bus.mem_wren), 256'(0));
        check({tag, "_idle_ldv"}, 256'(bus.ld_valid), 256'(0));
    endtask
    task automatic access(input string tag, input logic w, input logic v, input logic [ADDR_W-1:0] a,
                          input vec_t wd, input logic [4:0] rd, input int lat, input vec_t exp_ld);
        int n;
        logic [ADDR_W-1:0] wa[$];
        bus.req_write   = w;
        bus.req_vector  = v;
        bus.req_addr    = a;
        bus.req_wdata_v = wd;
        bus.req_wdata_s = wd[0];
        bus.req_rd      = rd;
        bus.req_valid   = 1'b1;
        #1;
        if (!bus.stall) step();
        check({tag, "_acc_stall"}, 256'(bus.stall), 256'(1));
        n = 0;
        do begin
            step();
            n++;
            if (bus.mem_wren) wa.push_back(bus.mem_addr);
        end while (bus.stall && n < 64);
        check({tag, "_latency"}, 256'(n), 256'(lat));
        check({tag, "_ldv"}, 256'(bus.ld_valid), 256'(!w));
        if (w) begin
            check({tag, "_wren_beats"}, 256'(wa.size()), 256'(v ? VLEN : 1));
            foreach (wa[i]) check($sformatf("%s_addr%0d", tag, i), 256'(wa[i]), 256'(ADDR_W'(a + ADDR_W'(i))));
        end else begin
            check({tag, "_ld_data"}, bus.ld_data, exp_ld);
            check({tag, "_ld_rd"}, 256'(bus.ld_rd), 256'(rd));
        end
    endtask
    initial begin
        vec_t va, vb, vc, sv, exp_c;
        int n;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_vector = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata_s = '0;
        bus.req_wdata_v = '0;
        bus.req_rd = '0;
        for (int i = 0; i < VLEN; i++) begin
            va[i] = 16'hA000 + 16'(i);
            vb[i] = 16'hB000 + 16'(i);
            vc[i] = 16'hC000 + 16'(i);
            exp_c[i] = i < 5 ? vc[i] : 16'h0;
        end
        sv = '0;
        sv[0] = 16'h1234;
        repeat (2) step();
        check("rst_stall", 256'(bus.stall), 256'(0));
        check("rst_wren", 256'(bus.mem_wren), 256'(0));
        check("rst_addr", 256'(bus.mem_addr), 256'(0));
        check("rst_wdata", 256'(bus.mem_wdata), 256'(0));
        check("rst_ldv", 256'(bus.ld_valid), 256'(0));
        check("rst_ld_data", bus.ld_data, 256'(0));
        check("rst_ld_rd", 256'(bus.ld_rd), 256'(0));
        check("rst_cnt", 256'(stall_count), 256'(0));
        rst = 1'b1;
        idle("pre");
        access("vst", 1'b1, 1'b1, 19'h00100, va, 5'd0, 17, '0);
        idle("vst");
        access("vld", 1'b0, 1'b1, 19'h00100, '0, 5'd7, 18, va);
        idle("vld");
        check("vld_hold_data", bus.ld_data, va);
        check("vld_hold_rd", 256'(bus.ld_rd), 256'(7));
        access("sst", 1'b1, 1'b0, 19'h00020, sv, 5'd0, 2, '0);
        idle("sst");
        access("sld", 1'b0, 1'b0, 19'h00020, '0, 5'd3, 3, sv);
        idle("sld");
        access("wst", 1'b1, 1'b1, 19'h7FFF8, vb, 5'd0, 17, '0);
        idle("wst");
        access("wld", 1'b0, 1'b1, 19'h7FFF8, '0, 5'd4, 18, vb);
        idle("wld");
        bus.req_write = 1'b1;
        bus.req_vector = 1'b1;
        bus.req_addr = 19'h00200;
        bus.req_wdata_v = vc;
        bus.req_valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!(bus.mem_wren && bus.mem_addr == 19'h00205) && n < 32);
        check("mid_beat5_reached", 256'(bus.mem_addr), 256'(19'h00205));
        rst = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("mid_rst_wren", 256'(bus.mem_wren), 256'(0));
        check("mid_rst_stall", 256'(bus.stall), 256'(0));
        step();
        rst = 1'b1;
        step();
        check("mid_post_stall", 256'(bus.stall), 256'(0));
        check("mid_post_addr", 256'(bus.mem_addr), 256'(0));
        check("mid_post_cnt", 256'(stall_count), 256'(0));
        access("mld", 1'b0, 1'b1, 19'h00200, '0, 5'd9, 18, exp_c);
        idle("mld");
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        access("b2b0", 1'b0, 1'b1, 19'h00100, '0, 5'd1, 18, va);
        access("b2b1", 1'b0, 1'b1, 19'h7FFF8, '0, 5'd2, 18, vb);
        idle("b2b");
`ifdef VMEM_STALL_COUNT_EN
        check("b2b_stall_count", 256'(stall_count), 256'(34));
`else
        check("b2b_stall_count", 256'(stall_count), 256'(0));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
